nib_sched: RTL and testbench

NIB_SCHED -- requirements
Module: nib_sched

---
 rtl/nib_pkg.sv | 21 ++
 rtl/nib_rr_arb.sv | 34 +++
 rtl/nib_sched.sv | 118 +++++++++++
 tb/tb_nib_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/nib_pkg.sv
// Shared constants, FSM state type and nibble-select helper for the nibble scheduler.
package nib_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned NIBS   = 4;
  localparam int unsigned CNT_W  = $clog2(NIBS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Nibble that leaves the shift register next: top nibble when sending
  // most-significant first, bottom nibble otherwise.
  function automatic logic [NIB_W-1:0] lead_nib(input logic [WORD_W-1:0] w,
                                                input logic msn_first);
    return msn_first ? w[WORD_W-1 -: NIB_W] : w[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/nib_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, last winner drops to lower priority.
module nib_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // High when requester 1 currently holds priority.
  logic ptr_q;

  // Combinational grant; contention resolved by the priority pointer.
  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Pointer moves away from the winner, only on an actual grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (|gnt_o) begin
      ptr_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/nib_sched.sv
// Nibble scheduler: accepts 16-bit words from two requesters (round-robin)
// and streams each as four nibbles over a valid/ready nibble channel.
module nib_sched
  import nib_pkg::*;
#(
  parameter int unsigned MSN_FIRST = 1
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              REQ0_VALID,
  input  logic [WORD_W-1:0] REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [WORD_W-1:0] REQ1_DATA,
  output logic              REQ1_READY,
  output logic              NIB_VALID,
  output logic [NIB_W-1:0]  NIB_DATA,
  output logic              NIB_LAST,
  output logic              NIB_SRC,
  input  logic              NIB_READY,
  output logic              BUSY
);

  localparam logic MSN = (MSN_FIRST != 0);

  state_e            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] shreg_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              src_q;
  logic              nib_valid_q;
  logic [NIB_W-1:0]  nib_data_q;
  logic              nib_last_q;
  logic              busy_q;

  logic [1:0]        gnt;
  logic              arb_en;
  logic [WORD_W-1:0] word_in;

  // Grants are only possible in IDLE and never while reset is held.
  assign arb_en = (state_q == ST_IDLE) && RESET_L;

  nib_rr_arb u_arb (
    .clk_i  (CLK),
    .rst_ni (RESET_L),
    .req_i  ({REQ1_VALID, REQ0_VALID}),
    .en_i   (arb_en),
    .gnt_o  (gnt)
  );

  assign REQ0_READY = gnt[0];
  assign REQ1_READY = gnt[1];

  // Winning word and the post-consume shift of the in-flight word.
  always_comb begin
    word_in = gnt[1] ? REQ1_DATA : REQ0_DATA;
    shreg_d = MSN ? (shreg_q << NIB_W) : (shreg_q >> NIB_W);
  end

  // The shift register consumes from one end so the next nibble is always
  // the leading one; NIB_DATA is registered from that lead one cycle early.
  // Scheduler FSM with registered nibble-channel outputs.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      src_q       <= 1'b0;
      nib_valid_q <= 1'b0;
      nib_data_q  <= '0;
      nib_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            state_q     <= ST_SEND;
            shreg_q     <= word_in;
            cnt_q       <= '0;
            src_q       <= gnt[1];
            nib_valid_q <= 1'b1;
            nib_data_q  <= lead_nib(word_in, MSN);
            nib_last_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_SEND: begin
          if (NIB_READY) begin
            if (cnt_q == CNT_W'(NIBS - 1)) begin
              state_q     <= ST_IDLE;
              shreg_q     <= '0;
              cnt_q       <= '0;
              nib_valid_q <= 1'b0;
              nib_data_q  <= '0;
              nib_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              shreg_q     <= shreg_d;
              cnt_q       <= cnt_q + 1'b1;
              nib_data_q  <= lead_nib(shreg_d, MSN);
              nib_last_q  <= (cnt_q == CNT_W'(NIBS - 2));
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign NIB_VALID = nib_valid_q;
  assign NIB_DATA  = nib_data_q;
  assign NIB_LAST  = nib_last_q;
  assign NIB_SRC   = src_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_nib_sched.sv
// Directed bench for nib_sched: inputs change 1 ns after posedge,
// outputs are sampled on the negedge.
module tb_nib_sched;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        REQ0_VALID, REQ1_VALID;
  logic [15:0] REQ0_DATA, REQ1_DATA;
  logic        REQ0_READY, REQ1_READY;
  logic        NIB_VALID, NIB_LAST, NIB_SRC, BUSY;
  logic [3:0]  NIB_DATA;
  logic        NIB_READY;

  logic        L_REQ0_READY, L_REQ1_READY;
  logic        L_NIB_VALID, L_NIB_LAST, L_NIB_SRC, L_BUSY;
  logic [3:0]  L_NIB_DATA;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  nib_sched #(.MSN_FIRST(1)) dut (
    .CLK(CLK), .RESET_L(RESET_L),
    .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .NIB_VALID(NIB_VALID), .NIB_DATA(NIB_DATA), .NIB_LAST(NIB_LAST),
    .NIB_SRC(NIB_SRC), .NIB_READY(NIB_READY), .BUSY(BUSY)
  );

  nib_sched #(.MSN_FIRST(0)) dut_lsn (
    .CLK(CLK), .RESET_L(RESET_L),
    .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(L_REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(L_REQ1_READY),
    .NIB_VALID(L_NIB_VALID), .NIB_DATA(L_NIB_DATA), .NIB_LAST(L_NIB_LAST),
    .NIB_SRC(L_NIB_SRC), .NIB_READY(NIB_READY), .BUSY(L_BUSY)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check one cycle of the main DUT at negedge, then move to posedge+1.
  task automatic step(input string tag, input logic r0, input logic r1,
                      input logic v, input logic [3:0] d, input logic l, input logic s);
    @(negedge CLK);
    chk({tag, "_rdy0"}, 16'(REQ0_READY), 16'(r0));
    chk({tag, "_rdy1"}, 16'(REQ1_READY), 16'(r1));
    chk({tag, "_valid"}, 16'(NIB_VALID), 16'(v));
    chk({tag, "_busy"}, 16'(BUSY), 16'(v));
    chk({tag, "_data"}, 16'(NIB_DATA), 16'(d));
    chk({tag, "_last"}, 16'(NIB_LAST), 16'(l));
    if (v) chk({tag, "_src"}, 16'(NIB_SRC), 16'(s));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] wa [2];
    wa[0] = 16'hABCD;
    wa[1] = 16'h5678;

    // Reset with a request pending: nothing accepted, outputs quiet.
    RESET_L    = 1'b0;
    REQ0_VALID = 1'b1; REQ0_DATA = 16'h1234;
    REQ1_VALID = 1'b0; REQ1_DATA = 16'h0000;
    NIB_READY  = 1'b1;
    @(negedge CLK);
    chk("rst_rdy0", 16'(REQ0_READY), 16'h0);
    chk("rst_valid", 16'(NIB_VALID), 16'h0);
    chk("rst_data", 16'(NIB_DATA), 16'h0);
    chk("rst_busy", 16'(BUSY), 16'h0);
    @(posedge CLK); #1;
    RESET_L = 1'b1;

    // Single word 'h1234 from requester 0.
    step("t1_grant", 1, 0, 0, 4'h0, 0, 0);
    REQ0_VALID = 1'b0;
    step("t1_n1", 0, 0, 1, 4'h1, 0, 0);
    step("t1_n2", 0, 0, 1, 4'h2, 0, 0);
    step("t1_n3", 0, 0, 1, 4'h3, 0, 0);
    step("t1_n4", 0, 0, 1, 4'h4, 1, 0);
    step("t1_idle", 0, 0, 0, 4'h0, 0, 0);

    // Both requesting right after reset: requester 0 first, then 1.
    RESET_L = 1'b0; #2; RESET_L = 1'b1;
    REQ0_VALID = 1'b1; REQ0_DATA = 16'h1534;
    REQ1_VALID = 1'b1; REQ1_DATA = 16'h8234;
    step("t2_g0", 1, 0, 0, 4'h0, 0, 0);
    step("t2_a1", 0, 0, 1, 4'h1, 0, 0);
    step("t2_a2", 0, 0, 1, 4'h5, 0, 0);
    step("t2_a3", 0, 0, 1, 4'h3, 0, 0);
    step("t2_a4", 0, 0, 1, 4'h4, 1, 0);
    step("t2_g1", 0, 1, 0, 4'h0, 0, 0);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    step("t2_b1", 0, 0, 1, 4'h8, 0, 1);
    step("t2_b2", 0, 0, 1, 4'h2, 0, 1);
    step("t2_b3", 0, 0, 1, 4'h3, 0, 1);
    step("t2_b4", 0, 0, 1, 4'h4, 1, 1);
    step("t2_idle", 0, 0, 0, 4'h0, 0, 0);

    // Back-pressure on the second nibble of 'h1574.
    REQ0_VALID = 1'b1; REQ0_DATA = 16'h1574;
    step("t3_grant", 1, 0, 0, 4'h0, 0, 0);
    REQ0_VALID = 1'b0;
    step("t3_n1", 0, 0, 1, 4'h1, 0, 0);
    NIB_READY = 1'b0;
    step("t3_hold0", 0, 0, 1, 4'h5, 0, 0);
    step("t3_hold1", 0, 0, 1, 4'h5, 0, 0);
    step("t3_hold2", 0, 0, 1, 4'h5, 0, 0);
    NIB_READY = 1'b1;
    step("t3_n2", 0, 0, 1, 4'h5, 0, 0);
    step("t3_n3", 0, 0, 1, 4'h7, 0, 0);
    step("t3_n4", 0, 0, 1, 4'h4, 1, 0);
    step("t3_idle", 0, 0, 0, 4'h0, 0, 0);

    // Reset while 'h8234 is mid-flight.
    REQ1_VALID = 1'b1; REQ1_DATA = 16'h8234;
    step("t4_grant", 0, 1, 0, 4'h0, 0, 0);
    REQ1_VALID = 1'b0;
    step("t4_n1", 0, 0, 1, 4'h8, 0, 1);
    @(negedge CLK);
    chk("t4_n2_data", 16'(NIB_DATA), 16'h2);
    #2;
    RESET_L = 1'b0;
    #1;
    chk("t4_rst_valid", 16'(NIB_VALID), 16'h0);
    chk("t4_rst_data", 16'(NIB_DATA), 16'h0);
    chk("t4_rst_last", 16'(NIB_LAST), 16'h0);
    chk("t4_rst_src", 16'(NIB_SRC), 16'h0);
    chk("t4_rst_busy", 16'(BUSY), 16'h0);
    chk("t4_rst_rdy1", 16'(REQ1_READY), 16'h0);
    @(posedge CLK); #1;
    RESET_L = 1'b1;
    step("t4_after0", 0, 0, 0, 4'h0, 0, 0);
    step("t4_after1", 0, 0, 0, 4'h0, 0, 0);
    step("t4_after2", 0, 0, 0, 4'h0, 0, 0);

    // Requester 1 'h1234: MSN-first on dut, LSN-first on dut_lsn.
    REQ1_VALID = 1'b1; REQ1_DATA = 16'h1234;
    @(negedge CLK);
    chk("t5_rdy1", 16'(REQ1_READY), 16'h1);
    chk("t5_lsn_rdy1", 16'(L_REQ1_READY), 16'h1);
    @(posedge CLK); #1;
    REQ1_VALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("t5_msn_data", 16'(NIB_DATA), 16'(k + 1));
      chk("t5_lsn_data", 16'(L_NIB_DATA), 16'(4 - k));
      chk("t5_lsn_last", 16'(L_NIB_LAST), 16'(k == 3));
      chk("t5_lsn_src", 16'(L_NIB_SRC), 16'h1);
      chk("t5_lsn_valid", 16'(L_NIB_VALID), 16'h1);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("t5_lsn_idle", 16'(L_NIB_VALID), 16'h0);
    @(posedge CLK); #1;

    // Both requesters held valid for four words: grants alternate 0,1,0,1.
    REQ0_VALID = 1'b1; REQ0_DATA = wa[0];
    REQ1_VALID = 1'b1; REQ1_DATA = wa[1];
    for (int i = 0; i < 4; i++) begin
      step("t6_grant", ((i % 2) == 0), ((i % 2) == 1), 0, 4'h0, 0, 0);
      w = wa[i % 2];
      for (int k = 0; k < 4; k++) begin
        step("t6_nib", 0, 0, 1, w[15:12], (k == 3), ((i % 2) == 1));
        w = w << 4;
      end
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    step("t6_idle", 0, 0, 0, 4'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
